write_response_queue: RTL and testbench
=======================================

WRITE_RESPONSE_QUEUE -- requirements
Module: write_response_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4; number of buffered B responses; power of two, minimum 2.
REQ-002 SHALL have parameter RESP_W, default 2; BRESP width.
REQ-003 SHALL have parameter CNT_W, default 8; width of the error counter.
REQ-004 SHALL have parameter TIMEOUT, default 256; stall cycles before timeout is flagged; minimum 1.
REQ-005 SHALL have ACLK  input  1  sole clock; all state updates on the rising edge.
REQ-006 SHALL have ARESETn  input  1  asynchronous, active-high reset (asserted = 1, despite the name).
REQ-007 SHALL have s_BVALID  input  1  response valid from slave side.
REQ-008 SHALL have s_BREADY  output  1  queue can accept a response.
REQ-009 SHALL have s_BRESP  input  RESP_W  response code from slave side.
REQ-010 SHALL have m_BVALID  output  1  head response valid toward master.
REQ-011 SHALL have m_BREADY  input  1  master accepts head response.
REQ-012 SHALL have m_BRESP  output  RESP_W  head response code.
REQ-013 SHALL have count  output  log2(DEPTH)+1  current occupancy.
REQ-014 SHALL have err_cnt  output  CNT_W  saturating count of SLVERR/DECERR responses popped.
REQ-015 SHALL have timeout  output  1  sticky flag: head stalled TIMEOUT consecutive cycles.
REQ-016 SHALL have clr  input  1  synchronous clear of err_cnt and timeout only.

Function
REQ-017 SHALL push when s_BVALID && s_BREADY; pop when m_BVALID && m_BREADY.
REQ-018 SHALL drive s_BREADY = (count != DEPTH); combinational from state only, never from s_BVALID.
REQ-019 SHALL drive m_BVALID = (count != 0); m_BRESP = head entry; both from registers, no combinational path from s_* to m_*.
REQ-020 SHALL make a pushed response visible on m_BVALID/m_BRESP the cycle after the push (latency 1); no same-cycle bypass when empty.
REQ-021 SHALL preserve order; read and write pointers wrap modulo DEPTH.
REQ-022 SHALL, on simultaneous push and pop, leave count unchanged; when full only a pop can occur (s_BREADY low).
REQ-023 SHALL hold m_BRESP stable while m_BVALID && !m_BREADY.
REQ-024 SHALL increment err_cnt on a pop whose BRESP MSB = 1 (SLVERR 2'b10, DECERR 2'b11); saturate at all-ones.
REQ-025 SHALL count stall cycles (m_BVALID && !m_BREADY); reset the counter on a pop or when empty; set timeout when it reaches TIMEOUT; timeout stays set until clr or reset.
REQ-026 SHALL give clr priority over a same-cycle increment; err_cnt = 0 and timeout = 0 on the next edge.
REQ-027 SHALL leave queue contents and pointers unaffected by clr.

Reset
REQ-028 SHALL on ARESETn = 1, asynchronously: count = 0, pointers = 0, m_BVALID = 0, m_BRESP = 0, s_BREADY = 1 only after release (0 while asserted), err_cnt = 0, timeout = 0, stall counter = 0.
REQ-029 SHALL discard all buffered entries on reset mid-operation; no pop or push is recognised while reset is asserted.

Structure
REQ-030 SHALL take BRESP encodings (OKAY 2'b00, EXOKAY 2'b01, SLVERR 2'b10, DECERR 2'b11) from the shared package axi_lite_pkg.
REQ-031 SHALL implement storage in one sub-module, sync_fifo (parameters DEPTH, WIDTH); counters and the timeout watchdog live in the top.

Verification
REQ-032 SHALL cover: with DEPTH=4, push OKAY, SLVERR, DECERR, OKAY with m_BREADY=0 -> count=4, s_BREADY=0, m_BRESP=2'b00.
REQ-033 SHALL cover: drain of that queue with m_BREADY=1 -> pop order 00, 10, 11, 00; err_cnt=2; count=0 after 4 cycles.
REQ-034 SHALL cover: full queue with s_BVALID=1 and m_BREADY=1 -> one pop per cycle; push accepted only on cycles where s_BREADY=1; order preserved.
REQ-035 SHALL cover: TIMEOUT=8, one entry held with m_BREADY=0 -> timeout rises after the 8th stall cycle; holds after the pop; clears one cycle after clr.
REQ-036 SHALL cover: CNT_W=2, pop 5 SLVERR -> err_cnt saturates at 3.
REQ-037 SHALL cover: reset asserted with count=3 -> m_BVALID=0, count=0 immediately; first push after release appears on m_BVALID one cycle later.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite definitions: BRESP encodings and error classification.
package axi_lite_pkg;

  localparam int unsigned BRESP_W = 2;

  typedef enum logic [BRESP_W-1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } bresp_e;

  // SLVERR and DECERR share a set MSB; OKAY/EXOKAY do not.
  function automatic logic resp_is_err(input logic [BRESP_W-1:0] resp);
    return resp[BRESP_W-1];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Power-of-two circular buffer with registered occupancy; head is read from storage.
module sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign rdata = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the head is only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/write_response_queue.sv
// Buffers AXI B responses between slave and master sides, counting error
// responses delivered and flagging a head that stalls too long.
module write_response_queue
  import axi_lite_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned RESP_W  = 2,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic                   ACLK,
  input  logic                   ARESETn,
  input  logic                   s_BVALID,
  output logic                   s_BREADY,
  input  logic [RESP_W-1:0]      s_BRESP,
  output logic                   m_BVALID,
  input  logic                   m_BREADY,
  output logic [RESP_W-1:0]      m_BRESP,
  output logic [$clog2(DEPTH):0] count,
  output logic [CNT_W-1:0]       err_cnt,
  output logic                   timeout,
  input  logic                   clr
);

  localparam int unsigned SW = $clog2(TIMEOUT + 1);

  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic              stall;
  logic              err_pop;
  logic [RESP_W-1:0] head;
  logic [SW-1:0]     stall_cnt;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (RESP_W)
  ) u_fifo (
    .clk   (ACLK),
    .rst   (ARESETn),
    .push  (push),
    .pop   (pop),
    .wdata (s_BRESP),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Ready is held low for the whole time reset is asserted.
  assign s_BREADY = !ARESETn && !full;
  assign m_BVALID = !empty;
  assign m_BRESP  = empty ? '0 : head;

  assign push    = s_BVALID && s_BREADY;
  assign pop     = m_BVALID && m_BREADY;
  assign stall   = m_BVALID && !m_BREADY;
  assign err_pop = pop && resp_is_err(m_BRESP[RESP_W-1 -: BRESP_W]);

  // Stall watchdog and error statistics; clr wins over a same-cycle update.
  always_ff @(posedge ACLK or posedge ARESETn) begin
    if (ARESETn) begin
      stall_cnt <= '0;
      timeout   <= 1'b0;
      err_cnt   <= '0;
    end else begin
      if (!stall) begin
        stall_cnt <= '0;
      end else if (stall_cnt != SW'(TIMEOUT)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end

      if (clr) begin
        timeout <= 1'b0;
      end else if (stall && (stall_cnt == SW'(TIMEOUT - 1))) begin
        timeout <= 1'b1;
      end

      if (clr) begin
        err_cnt <= '0;
      end else if (err_pop && (err_cnt != '1)) begin
        err_cnt <= err_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_write_response_queue.sv
// Scoreboard bench for write_response_queue: directed scenarios plus random traffic.
module tb_write_response_queue;
  import axi_lite_pkg::*;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned RESP_W  = 2;
  localparam int unsigned CNT_W   = 2;
  localparam int unsigned TIMEOUT = 8;
  localparam int          ERR_MAX = (1 << CNT_W) - 1;

  logic                   ACLK = 1'b0;
  logic                   ARESETn = 1'b1;
  logic                   s_BVALID = 1'b0;
  logic                   s_BREADY;
  logic [RESP_W-1:0]      s_BRESP = '0;
  logic                   m_BVALID;
  logic                   m_BREADY = 1'b0;
  logic [RESP_W-1:0]      m_BRESP;
  logic [$clog2(DEPTH):0] count;
  logic [CNT_W-1:0]       err_cnt;
  logic                   timeout;
  logic                   clr = 1'b0;

  write_response_queue #(
    .DEPTH   (DEPTH),
    .RESP_W  (RESP_W),
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .ACLK     (ACLK),
    .ARESETn  (ARESETn),
    .s_BVALID (s_BVALID),
    .s_BREADY (s_BREADY),
    .s_BRESP  (s_BRESP),
    .m_BVALID (m_BVALID),
    .m_BREADY (m_BREADY),
    .m_BRESP  (m_BRESP),
    .count    (count),
    .err_cnt  (err_cnt),
    .timeout  (timeout),
    .clr      (clr)
  );

  always #5 ACLK = ~ACLK;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a queue of outstanding responses plus plain counters.
  logic [RESP_W-1:0] exp_q[$];
  int                m_err   = 0;
  int                m_stall = 0;
  bit                m_to    = 0;
  bit                do_push;
  bit                do_pop;
  bit                m_stalled;
  logic [RESP_W-1:0] popped;

  // Monitor: compare at the falling edge, then advance the model for the next rise.
  always @(negedge ACLK) begin
    if (ARESETn) begin
      exp_q.delete();
      m_err   = 0;
      m_stall = 0;
      m_to    = 0;
    end
    check("count", count, exp_q.size());
    check("s_bready", s_BREADY, (!ARESETn && exp_q.size() != DEPTH) ? 1 : 0);
    check("m_bvalid", m_BVALID, (exp_q.size() != 0) ? 1 : 0);
    check("m_bresp", m_BRESP, (exp_q.size() != 0) ? exp_q[0] : 0);
    check("err_cnt", err_cnt, m_err);
    check("timeout", timeout, m_to);
    if (!ARESETn) begin
      do_push   = s_BVALID && (exp_q.size() != DEPTH);
      do_pop    = m_BREADY && (exp_q.size() != 0);
      m_stalled = (exp_q.size() != 0) && !m_BREADY;
      if (do_pop) begin
        popped = exp_q.pop_front();
        check("pop_order", m_BRESP, popped);
        if (clr) m_err = 0;
        else if (popped[RESP_W-1] && m_err < ERR_MAX) m_err = m_err + 1;
      end else if (clr) begin
        m_err = 0;
      end
      if (do_push) exp_q.push_back(s_BRESP);
      m_stall = m_stalled ? m_stall + 1 : 0;
      if (clr) m_to = 0;
      else if (m_stalled && m_stall == TIMEOUT) m_to = 1;
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge ACLK);
    #1;
  endtask

  logic [RESP_W-1:0] pat [4];

  initial begin
    pat[0] = RESP_OKAY;
    pat[1] = RESP_SLVERR;
    pat[2] = RESP_DECERR;
    pat[3] = RESP_OKAY;

    // Reset state while asserted, then after release.
    cyc(2);
    check("rst_count", count, 0);
    check("rst_m_bvalid", m_BVALID, 0);
    check("rst_s_bready", s_BREADY, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_timeout", timeout, 0);
    ARESETn = 1'b0;
    cyc(1);
    check("post_rst_s_bready", s_BREADY, 1);

    // Fill with OKAY, SLVERR, DECERR, OKAY while the master is not ready.
    for (int i = 0; i < 4; i++) begin
      s_BVALID = 1'b1;
      s_BRESP  = pat[i];
      cyc(1);
    end
    s_BVALID = 1'b0;
    check("fill_count", count, 4);
    check("fill_s_bready", s_BREADY, 0);
    check("fill_head", m_BRESP, 0);

    // Drain in order.
    m_BREADY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_order", m_BRESP, pat[i]);
      cyc(1);
    end
    m_BREADY = 1'b0;
    check("drain_count", count, 0);
    check("drain_err_cnt", err_cnt, 2);
    check("drain_timeout", timeout, 0);

    // Full queue with both sides active.
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_BVALID = 1'b1;
      s_BRESP  = RESP_W'($urandom);
      cyc(1);
    end
    check("full_s_bready", s_BREADY, 0);
    m_BREADY = 1'b1;
    s_BRESP  = RESP_W'($urandom);
    cyc(1);
    check("full_first_pop_count", count, 3);
    check("full_first_pop_ready", s_BREADY, 1);
    for (int i = 0; i < 7; i++) begin
      s_BRESP = RESP_W'($urandom);
      cyc(1);
    end
    check("full_stream_count", count, 3);
    s_BVALID = 1'b0;
    cyc(3);
    check("full_drain_count", count, 0);
    m_BREADY = 1'b0;

    // Timeout after TIMEOUT stall cycles; sticky across the pop; cleared by clr.
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    s_BVALID = 1'b1;
    s_BRESP  = RESP_OKAY;
    cyc(1);
    s_BVALID = 1'b0;
    cyc(TIMEOUT - 1);
    check("timeout_before", timeout, 0);
    cyc(1);
    check("timeout_set", timeout, 1);
    m_BREADY = 1'b1;
    cyc(1);
    m_BREADY = 1'b0;
    check("timeout_sticky", timeout, 1);
    check("timeout_pop_count", count, 0);
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    check("timeout_clr", timeout, 0);

    // Error counter saturation with five SLVERR responses.
    s_BVALID = 1'b1;
    s_BRESP  = RESP_SLVERR;
    m_BREADY = 1'b1;
    cyc(5);
    s_BVALID = 1'b0;
    cyc(2);
    m_BREADY = 1'b0;
    check("err_saturate", err_cnt, ERR_MAX);

    // Reset in the middle of operation with three entries queued.
    for (int i = 0; i < 3; i++) begin
      s_BVALID = 1'b1;
      s_BRESP  = RESP_W'($urandom);
      cyc(1);
    end
    s_BVALID = 1'b0;
    check("mid_count", count, 3);
    ARESETn = 1'b1;
    #1;
    check("mid_rst_m_bvalid", m_BVALID, 0);
    check("mid_rst_count", count, 0);
    check("mid_rst_s_bready", s_BREADY, 0);
    cyc(1);
    ARESETn  = 1'b0;
    s_BVALID = 1'b1;
    s_BRESP  = RESP_DECERR;
    #1;
    check("release_m_bvalid_pre", m_BVALID, 0);
    cyc(1);
    s_BVALID = 1'b0;
    check("release_m_bvalid", m_BVALID, 1);
    check("release_m_bresp", m_BRESP, RESP_DECERR);
    m_BREADY = 1'b1;
    cyc(2);

    // Random traffic with phases of slow master to provoke timeouts.
    for (int i = 0; i < 3000; i++) begin
      s_BVALID = ($urandom_range(0, 99) < 60);
      s_BRESP  = RESP_W'($urandom);
      if (((i / 64) % 2) == 0) m_BREADY = ($urandom_range(0, 99) < 50);
      else                     m_BREADY = ($urandom_range(0, 99) < 5);
      clr     = ($urandom_range(0, 99) == 0);
      ARESETn = ($urandom_range(0, 399) == 0);
      cyc(1);
    end

    ARESETn  = 1'b0;
    s_BVALID = 1'b0;
    m_BREADY = 1'b0;
    clr      = 1'b0;
    cyc(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
